// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: state/owner encodings and default widths shared by the RAM arbiter files.
package ram_arb_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU_ISSUE = 2'd1,
        DMA_ISSUE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;
endpackage

// File: rtl/ram_arb_resp.sv
// ram_arb_resp: one-deep response stage that steers RAM read data to whichever port issued
// the access in the previous cycle; each read-data output holds its last value between responses.
module ram_arb_resp
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  owner_e            issue_owner,
    input  logic              issue_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              dma_valid,
    output logic [DATA_W-1:0] dma_rdata
);
    // owner/valid kept decoded per port so ACK and VALID leave straight from flops
    logic              cpu_ack_q, cpu_ack_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic              dma_valid_q, dma_valid_d;
    logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
    logic [DATA_W-1:0] dma_hold_q, dma_hold_d;

    always_comb begin
        cpu_ack_d   = issue_valid & (issue_owner == OWN_CPU);
        cpu_rd_d    = cpu_ack_d & ~issue_we;
        dma_valid_d = issue_valid & (issue_owner == OWN_DMA);
        cpu_rdata   = cpu_rd_q ? ram_rdata : cpu_hold_q;
        dma_rdata   = dma_valid_q ? ram_rdata : dma_hold_q;
        cpu_hold_d  = cpu_rdata;
        dma_hold_d  = dma_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
            dma_valid_q <= 1'b0;
            cpu_hold_q  <= '0;
            dma_hold_q  <= '0;
        end else begin
            cpu_ack_q   <= cpu_ack_d;
            cpu_rd_q    <= cpu_rd_d;
            dma_valid_q <= dma_valid_d;
            cpu_hold_q  <= cpu_hold_d;
            dma_hold_q  <= dma_hold_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_valid = dma_valid_q;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: CPU-priority arbiter sharing a single-port RAM with a read-only DMA stream.
// Define RAM_ARB_STATS_EN to add the saturating STALL_COUNT port.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK_100MHz,
    input  logic              RESET_N,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_ACK,
    input  logic              DMA_REQ,
    input  logic [ADDR_W-1:0] DMA_ADDR,
    output logic              DMA_ACK,
    output logic [DATA_W-1:0] DMA_RDATA,
    output logic              DMA_VALID,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA
`ifdef RAM_ARB_STATS_EN
    ,
    output logic [15:0]       STALL_COUNT
`endif
);
    state_e            state_q, state_d;
    logic              cpu_served_q, cpu_served_d;
    logic              cpu_pending;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              dma_ack_q, dma_ack_d;

    // cpu_served blocks re-issue of a held CPU_REQ until it is seen low once
    always_comb begin
        cpu_pending  = CPU_REQ & ~cpu_served_q;
        state_d      = cpu_pending ? CPU_ISSUE : (DMA_REQ ? DMA_ISSUE : IDLE);
        cpu_served_d = cpu_pending | (cpu_served_q & CPU_REQ);
        we_d         = cpu_pending & CPU_WE;
        addr_d       = cpu_pending ? CPU_ADDR : (DMA_REQ ? DMA_ADDR : '0);
        wdata_d      = cpu_pending ? CPU_WDATA : '0;
        dma_ack_d    = (state_d == DMA_ISSUE);
    end

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            cpu_served_q <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            dma_ack_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_served_q <= cpu_served_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            dma_ack_q    <= dma_ack_d;
        end
    end

    assign RAM_EN    = (state_q != IDLE);
    assign RAM_WE    = (state_q == CPU_ISSUE) & we_q;
    assign RAM_ADDR  = addr_q;
    assign RAM_WDATA = wdata_q;
    assign DMA_ACK   = dma_ack_q;

    ram_arb_resp #(.DATA_W(DATA_W)) u_resp (
        .clk        (CLK_100MHz),
        .rst_n      (RESET_N),
        .issue_valid(state_q != IDLE),
        .issue_owner(state_q == DMA_ISSUE ? OWN_DMA : OWN_CPU),
        .issue_we   (we_q),
        .ram_rdata  (RAM_RDATA),
        .cpu_ack    (CPU_ACK),
        .cpu_rdata  (CPU_RDATA),
        .dma_valid  (DMA_VALID),
        .dma_rdata  (DMA_RDATA)
    );

`ifdef RAM_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb
        stall_d = (DMA_REQ && !dma_ack_q && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;

    always_ff @(posedge CLK_100MHz or negedge RESET_N) begin
        if (!RESET_N)
            stall_q <= 16'd0;
        else
            stall_q <= stall_d;
    end

    assign STALL_COUNT = stall_q;
`endif
endmodule
